// File: rtl/cdc_xfer_scheduler.sv
// rtl/cdc_xfer_scheduler.sv - arbitrated single-payload transfer from in_clk to out_clk
//
// Purpose:
//   Arbitrates NUM_REQ in_clk-domain requesters and carries one payload at a time
//   into the out_clk domain. A four-phase req/ack handshake is used. The payload and
//   requester index sit in hold registers that stay stable while the handshake is open.
//   Because of that, the multi-bit hold bus can be sampled directly in out_clk.
//
// Configuration macro:
//   CDC_SCHED_FIXED_PRIO_EN - defined: fixed priority, lowest asserted index wins.
//                             undefined (default): round-robin starting at pointer r_ptr.
//
// Ports:
//   in_clk     in   source clock (arbiter, source FSM, ack synchronizer)
//   out_clk    in   destination clock (req synchronizer, dst outputs)
//   rst        in   asynchronous active-high reset for both domains
//   src_valid  in   [NUM_REQ] per-requester valid
//   src_data   in   [NUM_REQ*DATA_WIDTH] packed payloads, requester i at i*DATA_WIDTH
//   src_ready  out  [NUM_REQ] one-hot grant while idle, combinational
//   busy       out  high while a crossing is open
//   dst_valid  out  one out_clk cycle pulse per delivered payload
//   dst_data   out  [DATA_WIDTH] delivered payload, held until next delivery
//   dst_id     out  [ID_WIDTH] requester index of dst_data
`timescale 1ns/1ps
module cdc_xfer_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          in_clk,
  input  logic                          out_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            src_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
  output logic [NUM_REQ-1:0]            src_ready,
  output logic                          busy,
  output logic                          dst_valid,
  output logic [DATA_WIDTH-1:0]         dst_data,
  output logic [ID_WIDTH-1:0]           dst_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // source domain state
  state_t                r_state;
  logic                  r_busy;
  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [ID_WIDTH-1:0]   r_hold_id;
  logic                  r_ack_s1;
  logic                  r_ack_s2;

  // destination domain state
  logic                  r_req_s1;
  logic                  r_req_s2;
  logic                  r_req_s3;
  logic                  r_dst_valid;
  logic [DATA_WIDTH-1:0] r_dst_data;
  logic [ID_WIDTH-1:0]   r_dst_id;

  // arbiter
  logic [NUM_REQ-1:0]    w_rot;      // valids viewed from the search start
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_off;      // winner offset from the search start
  logic [ID_WIDTH-1:0]   w_gnt;      // absolute winner index
  logic [NUM_REQ-1:0]    w_gnt_vec;
  logic [DATA_WIDTH-1:0] w_gnt_data;

`ifdef CDC_SCHED_FIXED_PRIO_EN
  assign w_rot = src_valid;
  assign w_gnt = w_off;
`else
  localparam logic [ID_WIDTH:0] LP_NUM = (ID_WIDTH+1)'(NUM_REQ);

  logic [ID_WIDTH-1:0]   r_ptr;
  logic [2*NUM_REQ-1:0]  w_dbl;
  logic [ID_WIDTH:0]     w_sum;
  logic [ID_WIDTH:0]     w_wrap;
  logic [ID_WIDTH:0]     w_nxt_sum;
  logic [ID_WIDTH-1:0]   w_ptr_nxt;

  // Rotating a doubled copy right by the pointer makes bit k of w_rot the valid of
  // requester (p+k) mod NUM_REQ, so a plain lowest-bit search gives round-robin order.
  assign w_dbl     = {src_valid, src_valid} >> r_ptr;
  assign w_rot     = w_dbl[NUM_REQ-1:0];
  assign w_sum     = {1'b0, w_off} + {1'b0, r_ptr};
  assign w_wrap    = w_sum - LP_NUM;
  assign w_gnt     = (w_sum >= LP_NUM) ? w_wrap[ID_WIDTH-1:0] : w_sum[ID_WIDTH-1:0];
  assign w_nxt_sum = {1'b0, w_gnt} + (ID_WIDTH+1)'(1);
  assign w_ptr_nxt = (w_nxt_sum == LP_NUM) ? '0 : w_nxt_sum[ID_WIDTH-1:0];
`endif

  // lowest set bit of the rotated view
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_rot[k] && !w_found) begin
        w_found = 1'b1;
        w_off   = ID_WIDTH'(k);
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_WIDTH'(i)) begin
        w_gnt_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_gnt_vec = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt;
  assign src_ready = (r_state == S_IDLE && w_found) ? w_gnt_vec : '0;
  assign busy      = r_busy;

  // Source FSM. A grant in IDLE is always an acceptance since ready follows valid.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_req       <= 1'b0;
      r_hold_data <= '0;
      r_hold_id   <= '0;
`ifndef CDC_SCHED_FIXED_PRIO_EN
      r_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_hold_data <= w_gnt_data;
            r_hold_id   <= w_gnt;
            r_req       <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_REQ;
`ifndef CDC_SCHED_FIXED_PRIO_EN
            r_ptr       <= w_ptr_nxt;
`endif
          end
        end
        S_REQ: begin
          if (r_ack_s2) begin
            r_req   <= 1'b0;
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          // hold registers stay frozen until the ack has fully returned low
          if (!r_ack_s2) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ack (destination req_s2) into in_clk
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
    end else begin
      r_ack_s1 <= r_req_s2;
      r_ack_s2 <= r_ack_s1;
    end
  end

  // Destination: req synchronizer plus edge flop. The rising edge of req_s2 is
  // the point where hold_data/hold_id are known stable in this domain.
  always_ff @(posedge out_clk or posedge rst) begin
    if (rst) begin
      r_req_s1    <= 1'b0;
      r_req_s2    <= 1'b0;
      r_req_s3    <= 1'b0;
      r_dst_valid <= 1'b0;
      r_dst_data  <= '0;
      r_dst_id    <= '0;
    end else begin
      r_req_s1    <= r_req;
      r_req_s2    <= r_req_s1;
      r_req_s3    <= r_req_s2;
      r_dst_valid <= r_req_s2 & ~r_req_s3;
      if (r_req_s2 && !r_req_s3) begin
        r_dst_data <= r_hold_data;
        r_dst_id   <= r_hold_id;
      end
    end
  end

  assign dst_valid = r_dst_valid;
  assign dst_data  = r_dst_data;
  assign dst_id    = r_dst_id;

endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// tb/tb_cdc_xfer_scheduler.sv - self-checking bench for cdc_xfer_scheduler
`timescale 1ns/100ps
module tb_cdc_xfer_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            in_clk    = 1'b0;
  logic            out_clk   = 1'b0;
  logic            rst       = 1'b1;
  logic [N-1:0]    src_valid = '0;
  logic [N*DW-1:0] src_data  = '0;
  logic [N-1:0]    src_ready;
  logic            busy;
  logic            dst_valid;
  logic [DW-1:0]   dst_data;
  logic [IW-1:0]   dst_id;

  realtime in_half  = 5.0;
  realtime out_half = 15.0;

  int checks = 0;
  int errors = 0;

  // requester stimulus state: transfers left, idle gap, current payload
  int            rem [N];
  int            gap [N];
  logic [DW-1:0] pay [N];
  bit            gap_en = 1'b0;
  int            m_ptr  = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] id;
  } xfer_t;

  xfer_t         expq[$];
  int            id_log[$];
  int            delivered = 0;
  logic [DW-1:0] last_d  = '0;
  logic [IW-1:0] last_id = '0;

  cdc_xfer_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .in_clk    (in_clk),
    .out_clk   (out_clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .busy      (busy),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_id    (dst_id)
  );

  always begin #(in_half);  in_clk  = ~in_clk;  end
  always begin #(out_half); out_clk = ~out_clk; end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first asserted requester scanning upward from the pointer.
  function automatic int model_pick(input logic [N-1:0] v);
    int start;
`ifdef CDC_SCHED_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_valid[i]           = (rem[i] > 0) && (gap[i] == 0);
      src_data[i*DW +: DW]   = pay[i];
    end
  endtask

  // One in_clk cycle: sample grant on the falling edge, apply new stimulus after the rise.
  task automatic cycle();
    int           w;
    int           a;
    logic [N-1:0] acc;
    logic [N-1:0] exp_rdy;
    xfer_t        e;
    a = -1;
    @(negedge in_clk);
    acc = src_ready & src_valid;
    if (!rst && src_ready != '0) begin
      w = model_pick(src_valid);
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("grant_onehot", src_ready, exp_rdy);
      chk("ready_while_busy", busy, 0);
      for (int i = N - 1; i >= 0; i--) if (acc[i]) a = i;
      if (w >= 0 && a >= 0) begin
        e.d  = pay[w];
        e.id = IW'(w);
        expq.push_back(e);
        m_ptr = (w + 1) % N;
      end
    end
    @(posedge in_clk);
    #1;
    for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
    if (a >= 0 && rem[a] > 0) begin
      rem[a]--;
      pay[a] = $urandom;
      gap[a] = gap_en ? int'($urandom_range(3, 0)) : 0;
    end
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (n < budget && (pend || busy || expq.size() != 0)) begin
      cycle();
      n++;
      pend = 1'b0;
      for (int i = 0; i < N; i++) if (rem[i] > 0) pend = 1'b1;
    end
    chk({tag, "_timeout"}, (n < budget), 1);
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      gap[i] = 0;
    end
    drive();
    rst = 1'b1;
    #2;
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_dst_valid"}, dst_valid, 0);
    chk({tag, "_dst_data"},  dst_data,  0);
    chk({tag, "_dst_id"},    dst_id,    0);
    repeat (3) @(posedge in_clk);
    expq.delete();
    m_ptr = 0;
    @(negedge in_clk);
    rst = 1'b0;
    @(posedge in_clk);
    #1;
  endtask

  task automatic run_random(input int count, input string tag);
    int d0;
    d0 = delivered;
    gap_en = 1'b1;
    for (int k = 0; k < count; k++) rem[$urandom_range(N - 1, 0)]++;
    for (int i = 0; i < N; i++) begin
      pay[i] = $urandom;
      gap[i] = int'($urandom_range(3, 0));
    end
    drive();
    drain(tag, 20000);
    chk({tag, "_count"}, delivered - d0, count);
    gap_en = 1'b0;
  endtask

  // Delivery monitor: every pulse must consume exactly one expected transfer in order.
  always @(negedge out_clk) begin
    xfer_t e;
    if (rst) begin
      last_d  = '0;
      last_id = '0;
    end else if (dst_valid === 1'b1) begin
      checks++;
      assert (expq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_delivery observed id=%0d data=%0h expected none", dst_id, dst_data);
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("dst_data", dst_data, e.d);
        chk("dst_id",   dst_id,   e.id);
      end
      delivered++;
      id_log.push_back(int'(dst_id));
      last_d  = dst_data;
      last_id = dst_id;
    end else begin
      chk("dst_data_hold", dst_data, last_d);
      chk("dst_id_hold",   dst_id,   last_id);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    int n2;
    int exp_seq [5];

    for (int i = 0; i < N; i++) pay[i] = '0;
    do_reset("init");

    // single transfer from requester 0
    d0 = delivered;
    rem[0] = 1;
    pay[0] = 32'hDEADBEEF;
    drive();
    drain("single", 500);
    chk("single_count",    delivered - d0, 1);
    chk("single_busy",     busy,           0);
    chk("single_dst_data", dst_data,       32'hDEADBEEF);
    chk("single_dst_id",   dst_id,         0);

    // all requesters held valid: grant order after reset
    do_reset("rst_seq");
    id_log.delete();
    rem[0] = 2;
    for (int i = 1; i < N; i++) rem[i] = 1;
    for (int i = 0; i < N; i++) pay[i] = 32'hA5A5_0000 + i;
    drive();
    drain("seq", 1000);
`ifdef CDC_SCHED_FIXED_PRIO_EN
    exp_seq = '{0, 0, 1, 2, 3};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    chk("seq_len", id_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("seq_id%0d", k), (k < id_log.size()) ? id_log[k] : -1, exp_seq[k]);
    end

    // fast destination, slow source
    in_half  = 20.0;
    out_half = 2.5;
    do_reset("rst_fastdst");
    run_random(100, "rand_fastdst");

    // slow destination, fast source
    in_half  = 5.0;
    out_half = 15.0;
    do_reset("rst_slowdst");
    run_random(40, "rand_slowdst");

    // reset while the source FSM sits in REQ
    rem[0] = 1;
    pay[0] = 32'hCAFEF00D;
    drive();
    n = 0;
    while (!busy && n < 10) begin
      cycle();
      n++;
    end
    chk("abort_busy_seen", busy, 1);
    cycle();
    d0 = delivered;
    do_reset("abort");
    repeat (40) cycle();
    chk("abort_no_delivery", delivered - d0, 0);

    id_log.delete();
    d0 = delivered;
    for (int i = 0; i < N; i++) begin
      rem[i] = 1;
      pay[i] = $urandom;
    end
    pay[0] = 32'h12345678;
    drive();
    drain("post_abort", 1000);
    chk("post_abort_count",    delivered - d0, 4);
    chk("post_abort_first_id", (id_log.size() > 0) ? id_log[0] : -1, 0);

    // requester 2 withdraws while requester 1 is in flight
    id_log.delete();
    d0 = delivered;
    rem[1] = 1;
    pay[1] = 32'h1111_0001;
    drive();
    n = 0;
    while (!busy && n < 10) begin
      cycle();
      n++;
    end
    chk("withdraw_busy_seen", busy, 1);
    rem[2] = 1;
    pay[2] = 32'h2222_0002;
    drive();
    repeat (3) cycle();
    rem[2] = 0;
    drive();
    drain("withdraw", 1000);
    chk("withdraw_count", delivered - d0, 1);
    n2 = 0;
    foreach (id_log[k]) if (id_log[k] == 2) n2++;
    chk("withdraw_no_id2", n2, 0);
    repeat (20) cycle();
    chk("withdraw_final_count", delivered - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_xfer_scheduler.md
CDC_XFER_SCHEDULER -- requirements
Module: cdc_xfer_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of source requesters (2..16).
REQ-002 Parameter DATA_WIDTH, default 32, payload width per requester.
REQ-003 Parameter ID_WIDTH, default 2, width of dst_id; SHALL be >= clog2(NUM_REQ).
REQ-004 in_clk  input  1  source-domain clock; arbiter, source handshake, req flop.
REQ-005 out_clk  input  1  destination-domain clock; dst outputs, ack flop.
REQ-006 rst  input  1  reset, asynchronous, active-high, applied to both domains.
REQ-007 src_valid  input  NUM_REQ  per-requester valid, in_clk domain.
REQ-008 src_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 src_ready  output  NUM_REQ  per-requester ready, in_clk domain, combinational.
REQ-010 busy  output  1  high while a crossing is in progress, in_clk domain.
REQ-011 dst_valid  output  1  one-out_clk-cycle pulse marking new dst_data/dst_id.
REQ-012 dst_data  output  DATA_WIDTH  delivered payload, out_clk domain, registered.
REQ-013 dst_id  output  ID_WIDTH  index of the requester that sourced dst_data, registered.

Function
REQ-014 Source FSM (in_clk) SHALL have states IDLE, REQ, DROP.
REQ-015 In IDLE with any src_valid high, src_ready SHALL be one-hot on the arbitration winner; in all other cases src_ready SHALL be 0.
REQ-016 A transfer is accepted on an in_clk edge with src_valid[g] & src_ready[g]; hold_data <= src_data[g], hold_id <= g, req <= 1, IDLE -> REQ.
REQ-017 Sources SHALL hold src_valid and src_data stable until accepted; src_valid deassertion before acceptance withdraws the request with no side effect.
REQ-018 REQ -> DROP when the in_clk-synchronized ack (two flops) reads 1; req <= 0.
REQ-019 DROP -> IDLE when the synchronized ack reads 0; the next grant is possible in that same IDLE cycle.
REQ-020 busy SHALL be 1 in REQ and DROP, 0 in IDLE.
REQ-021 hold_data/hold_id SHALL change only on acceptance and SHALL stay stable while req or synchronized ack is high.
REQ-022 Destination side SHALL synchronize req through two out_clk flops (req_s2) plus one edge flop (req_s3).
REQ-023 On req_s2 & ~req_s3: dst_data <= hold_data, dst_id <= hold_id, dst_valid <= 1 for exactly one out_clk cycle.
REQ-024 dst_valid SHALL first be high after the 3rd out_clk edge following req rising; dst_data/dst_id SHALL hold until the next delivery.
REQ-025 ack returned to in_clk SHALL be req_s2 (registered in out_clk domain).
REQ-026 Exactly one dst_valid pulse SHALL occur per accepted transfer; no drops or duplicates for any in_clk/out_clk ratio.
REQ-027 Default arbitration SHALL be round-robin: the search starts at pointer p; after granting g, p <= (g+1) mod NUM_REQ.
REQ-028 Requesters not asserting src_valid SHALL be skipped without consuming a turn.

Reset
REQ-029 On rst: FSM IDLE, req 0, hold_data 0, hold_id 0, p 0, ack sync flops 0.
REQ-030 On rst: req_s1/req_s2/req_s3 0, dst_valid 0, dst_data 0, dst_id 0.
REQ-031 rst asserted mid-transfer SHALL abort it without a dst_valid pulse after reset release; the aborted requester SHALL need re-acceptance.
REQ-032 After rst deassertion, requester 0 SHALL hold highest priority.

Configuration
REQ-033 Macro CDC_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest asserted index wins; pointer p not implemented.
REQ-034 Macro CDC_SCHED_FIXED_PRIO_EN undefined: round-robin per REQ-027/REQ-028.

Verification
REQ-035 in_clk 100 MHz, out_clk 33 MHz, src_valid=0001, data 0xDEADBEEF -> one dst_valid, dst_data 0xDEADBEEF, dst_id 0, busy returns 0.
REQ-036 src_valid=1111 held, distinct payloads, round-robin -> dst_id sequence 0,1,2,3,0; each payload exactly once.
REQ-037 Same stimulus with CDC_SCHED_FIXED_PRIO_EN -> dst_id 0 on every delivery while src_valid[0] is high.
REQ-038 in_clk 25 MHz, out_clk 200 MHz, 100 random transfers -> 100 dst_valid pulses, data/id match, src_ready never high while busy.
REQ-039 rst pulsed while in REQ -> all outputs 0, no dst_valid after release; new transfer 0x12345678 delivers correctly.
REQ-040 src_valid[2] dropped before acceptance while requester 1 is in flight -> no delivery with dst_id 2.
